// File: rtl/cache_sched_pkg.sv
// Shared types and helpers for the cache request scheduler: FSM state encoding,
// legal op codes and a saturating increment used by the statistics counters.
package cache_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    // Increment that sticks at 2^width-1 instead of wrapping; width must be 1..32.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_v) ? max_v : (val + 32'd1);
    endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Stateless round-robin grant: searches from rr_ptr+1 (mod NUM_REQ) and returns
// the first requester found as a one-hot grant plus its index.
module cache_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int idx_s;

    // Priority search rotated one past the last winner.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx_s       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_valid && req[idx_s]) begin
                grant_valid  = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = IDX_W'(idx_s);
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/cache_req_scheduler.sv
// Round-robin scheduler sharing one cache engine port between NUM_REQ requesters.
// Optional engine-wait timeout is built when CACHE_SCHED_TIMEOUT_EN is defined.
module cache_req_scheduler
    import cache_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 48,
    parameter int OP_W           = 8,
    parameter int CNT_W          = 18,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_addr,
    output logic [OP_W-1:0]           eng_op,
    input  logic                      eng_done,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic                      resp_err,
    output logic                      busy,
    output logic [NUM_REQ*CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    sched_state_t       state_r, state_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   id_r, id_s;
    logic               err_r, err_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [OP_W-1:0]    op_r;
    logic               eng_start_r, busy_r, resp_err_r;
    logic [NUM_REQ-1:0] resp_valid_r;
    logic [CNT_W-1:0]   issue_cnt_r [NUM_REQ];
    logic [CNT_W-1:0]   err_cnt_r;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_valid_s;
    logic               hs_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [OP_W-1:0]    sel_op_s;
    logic               sel_op_ok_s;
    logic               timeout_hit_s;
    logic               err_inc_s;

    cache_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Grants are only offered in IDLE and never while reset is asserted.
    assign hs_s        = (state_r == ST_IDLE) && grant_valid_s && !reset;
    assign req_ready   = hs_s ? grant_s : '0;
    assign sel_addr_s  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
    assign sel_op_s    = req_op[grant_idx_s*OP_W +: OP_W];
    assign sel_op_ok_s = (sel_op_s == OP_W'(OP_READ)) || (sel_op_s == OP_W'(OP_WRITE));
    assign err_inc_s   = (state_s == ST_RESP) && (state_r != ST_RESP) && err_s;

`ifdef CACHE_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] wait_cnt_r;

    // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    assign timeout_hit_s = (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state, owner id and error flag for the access in flight.
    always_comb begin
        state_s = state_r;
        id_s    = id_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    id_s    = grant_idx_s;
                    err_s   = !sel_op_ok_s;
                    state_s = sel_op_ok_s ? ST_ISSUE : ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (eng_done) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    state_s = ST_RESP;
                end else if (timeout_hit_s) begin
                    state_s = ST_RESP;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next-state decode so they align with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            id_r         <= '0;
            err_r        <= 1'b0;
            addr_r       <= '0;
            op_r         <= '0;
            eng_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            resp_valid_r <= '0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            id_r    <= id_s;
            err_r   <= err_s;
            if (hs_s) begin
                rr_ptr_r <= grant_idx_s;
                addr_r   <= sel_addr_s;
                op_r     <= sel_op_s;
            end
            eng_start_r  <= (state_s == ST_ISSUE);
            busy_r       <= (state_s != ST_IDLE);
            resp_valid_r <= (state_s == ST_RESP) ? (ONE_HOT0 << id_s) : '0;
            resp_err_r   <= (state_s == ST_RESP) && err_s;
        end
    end

    // Saturating statistics: accepts per requester and error responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                issue_cnt_r[i] <= '0;
            end
            err_cnt_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs_s && (grant_idx_s == IDX_W'(i))) begin
                    issue_cnt_r[i] <= CNT_W'(sat_inc(32'(issue_cnt_r[i]), CNT_W));
                end
            end
            if (err_inc_s) begin
                err_cnt_r <= CNT_W'(sat_inc(32'(err_cnt_r), CNT_W));
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_flat
        assign issue_cnt[g*CNT_W +: CNT_W] = issue_cnt_r[g];
    end

    assign eng_start  = eng_start_r;
    assign eng_addr   = addr_r;
    assign eng_op     = op_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_cache_req_scheduler.sv
// Self-checking bench for cache_req_scheduler: directed scenarios plus randomized
// traffic compared against a transaction-level model of the arbitration and counters.
module tb_cache_req_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 48;
    localparam int OP_W    = 8;
    localparam int CNT_W   = 3;
    localparam int TO      = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*OP_W-1:0]   req_op = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      eng_start;
    logic [ADDR_W-1:0]         eng_addr;
    logic [OP_W-1:0]           eng_op;
    logic                      eng_done = 1'b0;
    logic [NUM_REQ-1:0]        resp_valid;
    logic                      resp_err;
    logic                      busy;
    logic [NUM_REQ*CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]          err_cnt;

    int errors = 0;
    int checks = 0;

    int m_rr;
    int m_issue [NUM_REQ];
    int m_err;

    cache_req_scheduler #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
        .req_ready(req_ready), .eng_start(eng_start), .eng_addr(eng_addr), .eng_op(eng_op),
        .eng_done(eng_done), .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy),
        .issue_cnt(issue_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int model_winner(input logic [NUM_REQ-1:0] mask, input int rr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (mask[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic bit op_ok(input logic [7:0] op);
        return (op == 8'h52) || (op == 8'h57);
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic int cnt_of(input int i);
        return int'(issue_cnt[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_accept(input int w, input logic [7:0] op);
        m_rr = w;
        m_issue[w] = sat(m_issue[w]);
        if (!op_ok(op)) m_err = sat(m_err);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        req_valid = 2'b11;
        eng_done = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = '0;
        m_rr = 0;
        m_err = 0;
        for (int i = 0; i < NUM_REQ; i++) m_issue[i] = 0;
    endtask

    // Drives one request, acts as the engine (done 'delay' cycles after eng_start, -1 = never)
    // and reports what happened. lat counts cycles after the handshake edge.
    task automatic transact(input logic [NUM_REQ-1:0] mask, input logic [47:0] a0, input logic [47:0] a1,
                            input logic [7:0] o0, input logic [7:0] o1, input int delay,
                            output int gnt, output int lat, output int start_lat,
                            output logic [NUM_REQ-1:0] rmask, output logic rerr,
                            output logic [47:0] s_addr, output logic [7:0] s_op);
        bit got;
        gnt = -1; lat = -1; start_lat = 0; rmask = '0; rerr = 1'b0; s_addr = '0; s_op = '0;
        req_addr = {a1, a0};
        req_op = {o1, o0};
        req_valid = mask;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                got = 1'b1;
                gnt = req_ready[1] ? 1 : 0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        if (got) begin
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (resp_valid != '0) begin
                    rmask = resp_valid;
                    rerr = resp_err;
                    lat = c;
                    break;
                end
                if (eng_start) begin
                    start_lat = c;
                    s_addr = eng_addr;
                    s_op = eng_op;
                end
                eng_done = (start_lat != 0 && (c - start_lat) == delay);
            end
            eng_done = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b expected 0", eng_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (issue_cnt !== '0 || err_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", issue_cnt, err_cnt); end
        checks++; if (resp_valid !== 2'b00 || eng_addr !== '0 || eng_op !== '0) begin errors++; $display("FAIL reset_outputs: got resp %b addr %h op %h expected zeros", resp_valid, eng_addr, eng_op); end
        do_reset(1);
    endtask

    task automatic test_single();
        int gnt, lat, sl; logic [1:0] rm; logic re; logic [47:0] sa; logic [7:0] so;
        do_reset(2);
        transact(2'b01, 48'h0000_0000_1A40, 48'h0, 8'h52, 8'h52, 2, gnt, lat, sl, rm, re, sa, so);
        model_accept(0, 8'h52);
        checks++; if (gnt !== 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", gnt); end
        checks++; if (sl !== 1) begin errors++; $display("FAIL single_start_latency: got %0d expected 1", sl); end
        checks++; if (sa !== 48'h1A40 || so !== 8'h52) begin errors++; $display("FAIL single_eng_addr: got %h/%h expected 1a40/52", sa, so); end
        checks++; if (rm !== 2'b01 || re !== 1'b0) begin errors++; $display("FAIL single_resp: got %b err %b expected 01 err 0", rm, re); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL single_resp_latency: got %0d expected 4", lat); end
        checks++; if (cnt_of(0) !== 1 || busy !== 1'b0) begin errors++; $display("FAIL single_count: got %0d busy %b expected 1 busy 0", cnt_of(0), busy); end
        checks++; if (eng_addr !== 48'h1A40) begin errors++; $display("FAIL single_addr_hold: got %h expected 1a40", eng_addr); end
    endtask

    task automatic test_alternate();
        int gnt, lat, sl, w; logic [1:0] rm; logic re; logic [47:0] sa; logic [7:0] so;
        int exp_seq [6] = '{1, 0, 1, 0, 1, 0};
        do_reset(2);
        for (int n = 0; n < 6; n++) begin
            transact(2'b11, 48'h100 + 48'(n), 48'h200 + 48'(n), 8'h57, 8'h52, n % 3, gnt, lat, sl, rm, re, sa, so);
            w = model_winner(2'b11, m_rr);
            checks++; if (gnt !== exp_seq[n] || gnt !== w) begin errors++; $display("FAIL alt_grant[%0d]: got %0d expected %0d", n, gnt, exp_seq[n]); end
            checks++; if (rm !== 2'(1 << exp_seq[n]) || lat !== (n % 3) + 2) begin errors++; $display("FAIL alt_resp[%0d]: got %b lat %0d expected %b lat %0d", n, rm, lat, 2'(1 << exp_seq[n]), (n % 3) + 2); end
            model_accept(exp_seq[n], 8'h52);
        end
        checks++; if (cnt_of(0) !== 3 || cnt_of(1) !== 3) begin errors++; $display("FAIL alt_counts: got %0d,%0d expected 3,3", cnt_of(1), cnt_of(0)); end
    endtask

    task automatic test_bad_op();
        int gnt, lat, sl; logic [1:0] rm; logic re; logic [47:0] sa; logic [7:0] so;
        do_reset(2);
        transact(2'b10, 48'h0, 48'hABC, 8'h52, 8'h58, 0, gnt, lat, sl, rm, re, sa, so);
        checks++; if (gnt !== 1 || sl !== 0) begin errors++; $display("FAIL bad_op_issue: got grant %0d start %0d expected 1 and no start", gnt, sl); end
        checks++; if (rm !== 2'b10 || re !== 1'b1 || lat !== 1) begin errors++; $display("FAIL bad_op_resp: got %b err %b lat %0d expected 10 err 1 lat 1", rm, re, lat); end
        checks++; if (err_cnt !== 3'd1 || cnt_of(1) !== 1) begin errors++; $display("FAIL bad_op_counts: got err %0d issue %0d expected 1/1", err_cnt, cnt_of(1)); end
    endtask

`ifdef CACHE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int gnt, lat, sl; logic [1:0] rm; logic re; logic [47:0] sa; logic [7:0] so;
        do_reset(2);
        transact(2'b01, 48'h55, 48'h0, 8'h52, 8'h52, -1, gnt, lat, sl, rm, re, sa, so);
        checks++; if (rm !== 2'b01 || re !== 1'b1) begin errors++; $display("FAIL timeout_resp: got %b err %b expected 01 err 1", rm, re); end
        checks++; if (lat !== TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TO + 2); end
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        checks++; if (err_cnt !== 3'd1 || busy !== 1'b0 || resp_valid !== 2'b00) begin errors++; $display("FAIL timeout_after: got err %0d busy %b resp %b expected 1/0/00", err_cnt, busy, resp_valid); end
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_reset_mid();
        bit got;
        do_reset(2);
        req_addr = {48'h0, 48'h77};
        req_op = {8'h52, 8'h52};
        req_valid = 2'b01;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = |(req_valid & req_ready);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        checks++; if (!got) begin errors++; $display("FAIL mid_handshake: got none expected a grant within 10 cycles"); end
        @(negedge clk);
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL mid_start: got %b expected 1", eng_start); end
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        eng_done = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0 || issue_cnt !== '0) begin errors++; $display("FAIL mid_reset: got resp %b busy %b cnt %h expected 00/0/0", resp_valid, busy, issue_cnt); end
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got resp %b busy %b expected 00/0", resp_valid, busy); end
        @(posedge clk);
        #1;
        m_rr = 0; m_err = 0; m_issue[0] = 0; m_issue[1] = 0;
    endtask

    task automatic test_saturation();
        int gnt, lat, sl; logic [1:0] rm; logic re; logic [47:0] sa; logic [7:0] so;
        do_reset(2);
        for (int n = 0; n < CNT_MAX + 2; n++) begin
            transact(2'b01, 48'(n), 48'h0, 8'h52, 8'h52, 0, gnt, lat, sl, rm, re, sa, so);
            model_accept(0, 8'h52);
        end
        for (int n = 0; n < CNT_MAX + 2; n++) begin
            transact(2'b10, 48'h0, 48'(n), 8'h52, 8'h3F, 0, gnt, lat, sl, rm, re, sa, so);
            model_accept(1, 8'h3F);
        end
        checks++; if (cnt_of(0) !== CNT_MAX || cnt_of(0) !== m_issue[0]) begin errors++; $display("FAIL sat_issue0: got %0d expected %0d", cnt_of(0), CNT_MAX); end
        checks++; if (cnt_of(1) !== CNT_MAX || int'(err_cnt) !== CNT_MAX) begin errors++; $display("FAIL sat_issue1_err: got %0d/%0d expected %0d/%0d", cnt_of(1), err_cnt, CNT_MAX, CNT_MAX); end
    endtask

    task automatic test_random();
        int gnt, lat, sl, w, d; logic [1:0] rm, mask; logic re; logic [47:0] sa; logic [7:0] so;
        logic [47:0] a [2]; logic [7:0] o [2];
        logic [7:0] op_tbl [4] = '{8'h52, 8'h57, 8'h58, 8'h00};
        do_reset(2);
        for (int n = 0; n < 40; n++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                a[i] = {16'($urandom), 32'($urandom)};
                o[i] = op_tbl[$urandom_range(0, 3)];
                if (o[i] == 8'h00) o[i] = 8'($urandom);
            end
            d = $urandom_range(0, 3);
            w = model_winner(mask, m_rr);
            transact(mask, a[0], a[1], o[0], o[1], d, gnt, lat, sl, rm, re, sa, so);
            checks++; if (gnt !== w) begin errors++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d", n, gnt, w); end
            checks++; if (rm !== 2'(1 << w) || re !== !op_ok(o[w])) begin errors++; $display("FAIL rnd_resp[%0d]: got %b err %b expected %b err %b", n, rm, re, 2'(1 << w), !op_ok(o[w])); end
            checks++; if (lat !== (op_ok(o[w]) ? d + 2 : 1)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, op_ok(o[w]) ? d + 2 : 1); end
            if (op_ok(o[w])) begin
                checks++; if (sl !== 1 || sa !== a[w] || so !== o[w]) begin errors++; $display("FAIL rnd_engine[%0d]: got start %0d %h/%h expected 1 %h/%h", n, sl, sa, so, a[w], o[w]); end
            end else begin
                checks++; if (sl !== 0) begin errors++; $display("FAIL rnd_no_start[%0d]: got start at %0d expected none", n, sl); end
            end
            if (w >= 0) model_accept(w, o[w]);
        end
        checks++; if (cnt_of(0) !== m_issue[0] || cnt_of(1) !== m_issue[1] || int'(err_cnt) !== m_err) begin errors++; $display("FAIL rnd_counts: got %0d,%0d err %0d expected %0d,%0d err %0d", cnt_of(0), cnt_of(1), err_cnt, m_issue[0], m_issue[1], m_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_bad_op();
`ifdef CACHE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
